// File: rtl/icache_fetch.sv
`default_nettype none
// icache_fetch: direct-mapped instruction cache; misses refill a full line by single-word bus beats.
// Optional ICACHE_STATS_EN adds saturating hit_count / miss_count outputs.
module icache_fetch #(
  parameter int NLINES = 8,
  parameter int WORDS  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcF,
  output logic [31:0] instrF,
  output logic        icache_stall,
  input  logic        invalidate,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int OB = $clog2(WORDS);
  localparam int IB = $clog2(NLINES);
  localparam int LW = 30 - OB;
  localparam int TW = LW - IB;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    FILL   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NLINES-1:0] valid_q, valid_d;
  logic [LW-1:0]     line_q, line_d;
  logic [OB-1:0]     beat_q, beat_d;
  logic              pend_inv_q, pend_inv_d;
  logic              data_we, tag_we;

  logic [TW-1:0] tag_mem  [NLINES];
  logic [31:0]   data_mem [NLINES*WORDS];

  logic [OB-1:0] off;
  logic [IB-1:0] idx, fill_idx;
  logic [TW-1:0] tag, fill_tag;
  logic          hit;
  logic          unused_ok;

  assign off       = pcF[OB+1:2];
  assign idx       = pcF[IB+OB+1:OB+2];
  assign tag       = pcF[31:IB+OB+2];
  assign fill_idx  = line_q[IB-1:0];
  assign fill_tag  = line_q[LW-1:IB];
  assign unused_ok = &{1'b0, pcF[1:0]};

  assign hit          = (state_q == IDLE) && valid_q[idx] && (tag_mem[idx] == tag);
  assign instrF       = hit ? data_mem[{idx, off}] : 32'h0;
  assign icache_stall = ~hit;
  assign mem_req      = (state_q == REFILL);
  assign mem_addr     = (state_q == REFILL) ? {line_q, beat_q, 2'b00} : 32'h0;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    line_d     = line_q;
    beat_d     = beat_q;
    pend_inv_d = pend_inv_q;
    data_we    = 1'b0;
    tag_we     = 1'b0;
    if (invalidate) valid_d = '0;
    case (state_q)
      IDLE: begin
        if (!hit) begin
          line_d     = pcF[31:OB+2];
          beat_d     = '0;
          pend_inv_d = 1'b0;
          state_d    = REFILL;
        end
      end
      REFILL: begin
        if (invalidate) pend_inv_d = 1'b1;
        if (mem_ready) begin
          data_we = 1'b1;
          // Last beat holds the counter so the address never leaves the line.
          if (beat_q == {OB{1'b1}}) begin
            state_d = FILL;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      FILL: begin
        tag_we            = 1'b1;
        valid_d[fill_idx] = ~(pend_inv_q | invalidate);
        if (invalidate) pend_inv_d = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      line_q     <= '0;
      beat_q     <= '0;
      pend_inv_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      line_q     <= line_d;
      beat_q     <= beat_d;
      pend_inv_q <= pend_inv_d;
    end
  end

  // Tag and data arrays are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (data_we && !reset) data_mem[{fill_idx, beat_q}] <= mem_rdata;
    if (tag_we && !reset)  tag_mem[fill_idx] <= fill_tag;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (hit && (hit_count_q != 32'hFFFF_FFFF)) hit_count_d = hit_count_q + 32'd1;
    if ((state_q == IDLE) && !hit && (miss_count_q != 32'hFFFF_FFFF))
      miss_count_d = miss_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_fetch.sv
`default_nettype none
// Bench for icache_fetch: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_icache_fetch;
  localparam int NLINES = 8;
  localparam int WORDS  = 4;
  localparam int OB     = 2;
  localparam int IB     = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        invalidate = 1'b0;
  logic        mem_ready = 1'b1;
  logic [31:0] pcF = 32'h0;
  logic [31:0] gen = 32'h0;
  logic [31:0] instrF, mem_addr, mem_rdata;
  logic        icache_stall, mem_req;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int checks = 0;
  int errors = 0;

  assign mem_rdata = mem_addr ^ 32'hA5A5_0000 ^ gen;
  always #5 clk = ~clk;

  icache_fetch #(.NLINES(NLINES), .WORDS(WORDS)) dut (
    .clk(clk),
    .reset(reset),
    .pcF(pcF),
    .instrF(instrF),
    .icache_stall(icache_stall),
    .invalidate(invalidate),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pending miss is a queue of bus addresses still to fetch,
  // followed by one commit cycle that installs the whole line.
  logic        mvalid [NLINES];
  logic [31:0] mtag   [NLINES];
  logic [31:0] mdata  [NLINES][WORDS];
  logic [31:0] mbuf   [WORDS];
  logic [31:0] mq[$];
  logic [31:0] mbase = 32'h0;
  logic [31:0] hits_m = 32'h0;
  logic [31:0] misses_m = 32'h0;
  bit          mfill = 1'b0;
  bit          mpend = 1'b0;
  bit          known = 1'b0;

  always @(negedge clk) begin : model
    int          idx, off, fidx;
    logic [31:0] tg, e_instr, e_addr;
    logic        e_stall, e_req, m_hit, busy;
    idx     = int'((pcF >> (OB + 2)) % NLINES);
    off     = int'((pcF >> 2) % WORDS);
    tg      = pcF >> (OB + IB + 2);
    m_hit   = 1'b0;
    e_instr = 32'h0;
    e_addr  = 32'h0;
    e_req   = 1'b0;
    e_stall = 1'b1;
    if (mq.size() > 0) begin
      e_req  = 1'b1;
      e_addr = mq[0];
    end else if (!mfill) begin
      m_hit   = mvalid[idx] && (mtag[idx] == tg);
      e_stall = !m_hit;
      if (m_hit) e_instr = mdata[idx][off];
    end
    if (known) begin
      check("instrF", instrF, e_instr);
      check("icache_stall", {31'h0, icache_stall}, {31'h0, e_stall});
      check("mem_req", {31'h0, mem_req}, {31'h0, e_req});
      check("mem_addr", mem_addr, e_addr);
`ifdef ICACHE_STATS_EN
      check("hit_count", hit_count, hits_m);
      check("miss_count", miss_count, misses_m);
`endif
    end
    busy = (mq.size() > 0) || mfill;
    if (reset) begin
      known = 1'b1;
      mq.delete();
      mfill    = 1'b0;
      mpend    = 1'b0;
      hits_m   = 32'h0;
      misses_m = 32'h0;
      for (int i = 0; i < NLINES; i++) mvalid[i] = 1'b0;
    end else if (known) begin
      if (invalidate) begin
        for (int i = 0; i < NLINES; i++) mvalid[i] = 1'b0;
        if (busy) mpend = 1'b1;
      end
      if (mq.size() > 0) begin
        if (mem_ready) begin
          mbuf[WORDS - mq.size()] = mq[0] ^ 32'hA5A5_0000 ^ gen;
          void'(mq.pop_front());
          if (mq.size() == 0) mfill = 1'b1;
        end
      end else if (mfill) begin
        fidx = int'((mbase >> (OB + 2)) % NLINES);
        mtag[fidx] = mbase >> (OB + IB + 2);
        for (int w = 0; w < WORDS; w++) mdata[fidx][w] = mbuf[w];
        mvalid[fidx] = !mpend;
        mfill = 1'b0;
      end else if (m_hit) begin
        if (hits_m != 32'hFFFF_FFFF) hits_m++;
      end else begin
        if (misses_m != 32'hFFFF_FFFF) misses_m++;
        mbase = (pcF >> (OB + 2)) << (OB + 2);
        mpend = 1'b0;
        for (int w = 0; w < WORDS; w++) mq.push_back(mbase + 32'(4 * w));
      end
    end
  end

  // Runs from the current cycle until the stall drops; inputs change only just after posedge.
  task automatic run_miss(input logic [31:0] base, input int wait_beat, input int wait_n,
                          input int inv_beat, output int stalls, output int beats);
    int waited;
    bit inv_done, done;
    waited = 0; inv_done = 1'b0; done = 1'b0; stalls = 0; beats = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (!icache_stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
      if (mem_req) begin
        check("refill_addr", mem_addr, base + 32'(4 * (beats % WORDS)));
        if (mem_ready) beats++;
      end
      @(posedge clk); #1;
      invalidate = (inv_beat >= 0) && !inv_done && (beats == inv_beat) && (cyc >= 1);
      if (invalidate) inv_done = 1'b1;
      mem_ready = !((beats == wait_beat) && (waited < wait_n));
      if (!mem_ready) waited++;
    end
    if (!done) check("miss_timeout", 32'd1, 32'd0);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    int st, nb;
    logic [31:0] addrs [3];
    logic [31:0] tags [4];
    addrs[0] = 32'h4; addrs[1] = 32'h8; addrs[2] = 32'hC;
    tags[0] = 32'h0; tags[1] = 32'h1; tags[2] = 32'h2; tags[3] = 32'h1AB_CDEF;

    // Cold miss from reset
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #2;
    check("reset_req", {31'h0, mem_req}, 32'h0);
    check("reset_addr", mem_addr, 32'h0);
    check("reset_stall", {31'h0, icache_stall}, 32'h1);
    check("reset_instr", instrF, 32'h0);
    run_miss(32'h0, -1, 0, -1, st, nb);
    check("cold_stalls", st, 6);
    check("cold_beats", nb, 4);
    check("cold_instr", instrF, 32'hA5A5_0000);

    // Hits in the same line
    foreach (addrs[i]) begin
      next_cycle();
      pcF = addrs[i];
      @(negedge clk);
      check("line_hit_stall", {31'h0, icache_stall}, 32'h0);
      check("line_hit_instr", instrF, addrs[i] ^ 32'hA5A5_0000);
      check("line_hit_req", {31'h0, mem_req}, 32'h0);
    end

    // Conflict on index 0
    next_cycle(); pcF = 32'h80;
    run_miss(32'h80, -1, 0, -1, st, nb);
    check("conflict_stalls", st, 6);
    check("conflict_instr", instrF, 32'hA5A5_0080);
    next_cycle(); pcF = 32'h0;
    run_miss(32'h0, -1, 0, -1, st, nb);
    check("reload_stalls", st, 6);
    check("reload_instr", instrF, 32'hA5A5_0000);

    // Three wait states at beat 2
    next_cycle(); pcF = 32'h48;
    run_miss(32'h40, 2, 3, -1, st, nb);
    check("wait_stalls", st, 9);
    check("wait_instr", instrF, 32'hA5A5_0048);

    // Reset in the middle of a refill
    next_cycle(); pcF = 32'h24;
    repeat (3) next_cycle();
    check("pre_reset_addr", mem_addr, 32'h28);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0; pcF = 32'h0;
    #2;
    check("midreset_req", {31'h0, mem_req}, 32'h0);
    check("midreset_addr", mem_addr, 32'h0);
    run_miss(32'h0, -1, 0, -1, st, nb);
    check("post_reset_stalls", st, 6);
    check("post_reset_instr", instrF, 32'hA5A5_0000);

    // Invalidate during refill from a fresh reset: line is refetched
    next_cycle(); reset = 1'b1;
    next_cycle(); reset = 1'b0; pcF = 32'h0;
    run_miss(32'h0, -1, 0, 1, st, nb);
    check("inv_stalls", st, 12);
    check("inv_beats", nb, 8);
    check("inv_instr", instrF, 32'hA5A5_0000);
`ifdef ICACHE_STATS_EN
    check("inv_miss_count", miss_count, 32'd2);
    check("inv_hit_count", hit_count, 32'd0);
`endif

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      next_cycle();
      reset      = ($urandom_range(0, 199) == 0);
      invalidate = ($urandom_range(0, 31) == 0);
      mem_ready  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) gen = $urandom;
      if (!icache_stall || ($urandom_range(0, 49) == 0))
        pcF = (tags[$urandom_range(0, 3)] << 7) | 32'($urandom_range(0, 127));
    end
    next_cycle();
    reset = 1'b0; invalidate = 1'b0;
    @(negedge clk);
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped instruction cache between the pipelined core's fetch stage and the slower main-memory bus.
- Takes the core's fetch PC and returns the instruction word combinationally on a hit.
- On a miss, raises a stall to the core and refills one full line by single-word bus beats.
- The core ORs `icache_stall` into its fetch/decode stall so that pcF stays stable until the stall drops.

Parameters:
- NLINES, 8, number of cache lines; power of two, ≥2.
- WORDS, 4, 32-bit words per line; power of two, ≥2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- pcF  input  32  fetch address from the core; bits [1:0] are ignored.
- instrF  output  32  instruction word; valid when icache_stall=0.
- icache_stall  output  1  core must hold pcF and stall fetch/decode.
- invalidate  input  1  one-cycle pulse that clears all valid bits.
- mem_req  output  1  bus read request, held until accepted.
- mem_addr  output  32  word-aligned bus read address.
- mem_ready  input  1  bus beat accepted; mem_rdata is valid this cycle.
- mem_rdata  input  32  bus read data.

Behaviour:
- Clock and reset: one clock, `clk`; `reset` is synchronous and active-high.
- Address split:
  - off = pcF[OB+1:2], with OB = log2(WORDS).
  - idx = pcF[IB+OB+1:OB+2], with IB = log2(NLINES).
  - tag = the remaining upper bits.
- Storage:
  - valid[NLINES], tag[NLINES], data[NLINES*WORDS].
  - Data and tag reads are combinational.
- hit = (state==IDLE) & valid[idx] & tag[idx]==tag.
- instrF = data[idx][off] when hit, else 32'h0.
- icache_stall = ~hit in IDLE; 1 in every other state.
- States and transitions:
  - IDLE: on a miss, latch line base = {pcF[31:OB+2], 0s}, clear beat=0, clear pend_inv, go to REFILL. The stall is high in this same cycle.
  - REFILL: mem_req=1, mem_addr = base + 4*beat.
    - On mem_ready: write mem_rdata into data[idx_latched][beat] and increment beat.
    - On the beat==WORDS-1 handshake, go to FILL.
    - mem_addr and mem_req hold steady while mem_ready=0.
  - FILL: write tag[idx_latched]; set valid[idx_latched]=~pend_inv. Go to IDLE. mem_req=0.
- Latency:
  - Hit: 0 cycles, same cycle as pcF.
  - Miss with mem_ready tied high: stall is high for WORDS+2 cycles (6 at default); the hit follows in the next cycle.
  - Each mem_ready=0 cycle adds one stall cycle.
- mem_req is 0 outside REFILL. mem_addr is 0 outside REFILL.
- invalidate:
  - Clears every valid bit in any state.
  - In REFILL or FILL it also sets pend_inv, so the line being refilled is written but left invalid; the next lookup misses again.
  - invalidate in the same cycle as a miss detected in IDLE: valid bits are cleared and the refill still starts.
- pcF changing during a stall is a core protocol violation. The cache uses only the latched base, then re-evaluates pcF in IDLE.
- Reset, including mid-refill: next cycle is IDLE, all valid=0, beat=0, pend_inv=0, mem_req=0, mem_addr=0. Data and tag arrays are not cleared. instrF=0 and icache_stall=1 while pcF misses.
- Wrap-around: beat counts 0..WORDS-1 and does not wrap past the line; mem_addr never crosses the line boundary.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- When defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0.
  - hit_count increments on each IDLE cycle with hit=1.
  - miss_count increments on each IDLE→REFILL transition.
  - Both counters saturate at 32'hFFFFFFFF; invalidate does not clear them.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Cold miss: reset, pcF=0x0, mem_ready=1, bus returns addr^0xA5A50000.
  - Expect mem_addr 0x0,0x4,0x8,0xC on consecutive cycles and icache_stall high for 6 cycles.
  - Then instrF=0xA5A50000 with stall=0.
- Line hits: after the cold miss, pcF=0x4,0x8,0xC on successive cycles.
  - Expect stall=0, instrF=0xA5A50004/08/0C, mem_req=0 throughout.
- Conflict: pcF=0x80 (idx 0, different tag).
  - Expect refill of 0x80..0x8C.
  - Then pcF=0x0 misses again and refills 0x0..0xC.
- Wait states: during refill, hold mem_ready=0 for 3 cycles at beat 2.
  - Expect mem_addr=0x8 and mem_req=1 held, total stall 9 cycles, correct data afterwards.
- Reset mid-refill: assert reset at beat 2.
  - Next cycle expect mem_req=0 and mem_addr=0.
  - After release, pcF=0x0 misses and refills from beat 0 at 0x0.
- Invalidate: pulse invalidate during REFILL.
  - After FILL, pcF=0x0 still misses and refills.
  - With ICACHE_STATS_EN defined: miss_count=2, hit_count=0.
